// File: rtl/plotter_pkg.sv
// Shared plotter definitions: sequencer state encoding and
// screen-coordinate width helpers used across the plotter pipeline.
package plotter_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    function automatic int x_width(input int hor_pixels);
        return $clog2(hor_pixels);
    endfunction

    function automatic int y_width(input int ver_pixels);
        return $clog2(ver_pixels);
    endfunction

endpackage

// File: rtl/plot_sequencer_if.sv
// Sample-stream, drawer-handshake and frame-control bundle
// between the evaluator, plot_sequencer and line_drawer.
interface plot_sequencer_if #(
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 9
);
    logic               frame_start;
    logic               busy;
    logic               frame_done;
    logic               sample_valid;
    logic               sample_ready;
    logic [Y_WIDTH-1:0] sample_y;
    logic               sample_last;
    logic               line_start;
    logic               line_ready;
    logic [X_WIDTH-1:0] line_x1;
    logic [X_WIDTH-1:0] line_x2;
    logic [Y_WIDTH-1:0] line_y1;
    logic [Y_WIDTH-1:0] line_y2;

    modport master (
        input  frame_start, sample_valid, sample_y, sample_last, line_ready,
        output busy, frame_done, sample_ready, line_start,
        output line_x1, line_x2, line_y1, line_y2
    );

    modport slave (
        output frame_start, sample_valid, sample_y, sample_last, line_ready,
        input  busy, frame_done, sample_ready, line_start,
        input  line_x1, line_x2, line_y1, line_y2
    );
endinterface

// File: rtl/plot_y_map.sv
// Function value to screen row: clamp to the last visible row,
// then optionally flip so larger values plot higher.
module plot_y_map #(
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int INVERT_Y          = 1,
    parameter int Y_WIDTH           = 9
) (
    input  logic [Y_WIDTH-1:0] y,
    output logic [Y_WIDTH-1:0] mapped
);
    localparam logic [Y_WIDTH-1:0] Y_MAX = Y_WIDTH'(VER_ACTIVE_PIXELS - 1);

    logic [Y_WIDTH-1:0] clamped;

    assign clamped = (y > Y_MAX) ? Y_MAX : y;
    assign mapped  = (INVERT_Y != 0) ? (Y_MAX - clamped) : clamped;
endmodule

// File: rtl/plot_sequencer.sv
// Turns a stream of sampled function values into line segments
// and issues them one at a time to line_drawer.
module plot_sequencer
    import plotter_pkg::*;
#(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int X_STEP            = 1,
    parameter int INVERT_Y          = 1
) (
    input  logic             clk,
    input  logic             rst,
    plot_sequencer_if.master bus
);
    localparam int X_WIDTH = x_width(HOR_ACTIVE_PIXELS);
    localparam int Y_WIDTH = y_width(VER_ACTIVE_PIXELS);
    localparam logic [X_WIDTH:0] X_LAST = (X_WIDTH+1)'(HOR_ACTIVE_PIXELS - 1);
    localparam logic [X_WIDTH:0] STEP   = (X_WIDTH+1)'(X_STEP);

    state_t             state;
    logic [X_WIDTH-1:0] x_cur;
    logic [X_WIDTH-1:0] x1;
    logic [X_WIDTH-1:0] x2;
    logic [Y_WIDTH-1:0] y1;
    logic [Y_WIDTH-1:0] y2;
    logic [Y_WIDTH-1:0] y_mapped;
    logic [X_WIDTH:0]   x_next;
    logic               first;
    logic               last_seen;
    logic               busy;
    logic               frame_done;
    logic               sample_ready;
    logic               line_start;

    plot_y_map #(
        .VER_ACTIVE_PIXELS(VER_ACTIVE_PIXELS),
        .INVERT_Y         (INVERT_Y),
        .Y_WIDTH          (Y_WIDTH)
    ) u_y_map (
        .y     (bus.sample_y),
        .mapped(y_mapped)
    );

    // One extra bit so the step past the right edge is visible
    assign x_next = {1'b0, x_cur} + STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            x_cur        <= '0;
            x1           <= '0;
            x2           <= '0;
            y1           <= '0;
            y2           <= '0;
            first        <= 1'b0;
            last_seen    <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            sample_ready <= 1'b0;
            line_start   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.frame_start) begin
                        x_cur        <= '0;
                        first        <= 1'b1;
                        busy         <= 1'b1;
                        sample_ready <= 1'b1;
                        state        <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (bus.sample_valid) begin
                        x2 <= x_cur;
                        y2 <= y_mapped;
                        // First sample of a frame draws a single pixel
                        if (first) begin
                            x1 <= x_cur;
                            y1 <= y_mapped;
                        end else begin
                            x1 <= x2;
                            y1 <= y2;
                        end
                        last_seen    <= bus.sample_last;
                        sample_ready <= 1'b0;
                        line_start   <= 1'b1;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.line_ready) begin
                        line_start <= 1'b0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.line_ready) begin
                        if (last_seen) begin
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= S_IDLE;
                        end else if (x_next > X_LAST) begin
                            sample_ready <= 1'b1;
                            state        <= S_DRAIN;
                        end else begin
                            x_cur        <= x_next[X_WIDTH-1:0];
                            first        <= 1'b0;
                            sample_ready <= 1'b1;
                            state        <= S_ACCEPT;
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.sample_valid && bus.sample_last) begin
                        busy         <= 1'b0;
                        sample_ready <= 1'b0;
                        frame_done   <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy         = busy;
    assign bus.frame_done   = frame_done;
    assign bus.sample_ready = sample_ready;
    assign bus.line_start   = line_start;
    assign bus.line_x1      = x1;
    assign bus.line_x2      = x2;
    assign bus.line_y1      = y1;
    assign bus.line_y2      = y2;
endmodule

// File: tb/tb_plot_sequencer.sv
// Bench for plot_sequencer: two configurations, each with a
// small drawer model, driven from a vector table plus corner sequences.
module tb_plot_sequencer;
    import plotter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    plot_sequencer_if #(.X_WIDTH(10), .Y_WIDTH(9)) a_if ();
    plot_sequencer_if #(.X_WIDTH(4),  .Y_WIDTH(9)) b_if ();

    plot_sequencer #(
        .HOR_ACTIVE_PIXELS(640), .VER_ACTIVE_PIXELS(480),
        .X_STEP(4), .INVERT_Y(1)
    ) dut_a (.clk(clk), .rst(rst), .bus(a_if));

    plot_sequencer #(
        .HOR_ACTIVE_PIXELS(16), .VER_ACTIVE_PIXELS(480),
        .X_STEP(5), .INVERT_Y(0)
    ) dut_b (.clk(clk), .rst(rst), .bus(b_if));

    typedef struct packed {
        logic       busy;
        logic       fd;
        logic       sready;
        logic       lstart;
        logic [9:0] x1;
        logic [8:0] y1;
        logic [9:0] x2;
        logic [8:0] y2;
    } obs_t;

    typedef struct {
        int         inst;
        bit         newf;
        logic [8:0] y;
        bit         last;
        int         x1;
        int         y1;
        int         x2;
        int         y2;
    } vec_t;

    obs_t       obs [2];
    logic       fs [2];
    logic       sv [2];
    logic       sl [2];
    logic [8:0] sy [2];
    logic       stall [2];
    logic       dbusy [2];
    logic [1:0] dcnt [2];
    logic       rdy [2];
    int         starts [2];
    int         n_chk = 0;
    int         n_fail = 0;
    vec_t       vt [11];

    assign a_if.frame_start  = fs[0];
    assign a_if.sample_valid = sv[0];
    assign a_if.sample_y     = sy[0];
    assign a_if.sample_last  = sl[0];
    assign a_if.line_ready   = rdy[0];
    assign b_if.frame_start  = fs[1];
    assign b_if.sample_valid = sv[1];
    assign b_if.sample_y     = sy[1];
    assign b_if.sample_last  = sl[1];
    assign b_if.line_ready   = rdy[1];

    assign rdy[0] = !dbusy[0] && !stall[0];
    assign rdy[1] = !dbusy[1] && !stall[1];

    assign obs[0] = {a_if.busy, a_if.frame_done, a_if.sample_ready,
                     a_if.line_start, a_if.line_x1, a_if.line_y1,
                     a_if.line_x2, a_if.line_y2};
    assign obs[1] = {b_if.busy, b_if.frame_done, b_if.sample_ready,
                     b_if.line_start, 6'd0, b_if.line_x1, b_if.line_y1,
                     6'd0, b_if.line_x2, b_if.line_y2};

    // Drawer model: ready drops for three cycles after each accepted start
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                dbusy[i] <= 1'b0;
                dcnt[i]  <= 2'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (dbusy[i]) begin
                    if (dcnt[i] == 2'd0) dbusy[i] <= 1'b0;
                    else dcnt[i] <= dcnt[i] - 2'd1;
                end else if (obs[i].lstart && rdy[i]) begin
                    dbusy[i]  <= 1'b1;
                    dcnt[i]   <= 2'd2;
                    starts[i] <= starts[i] + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_frame(input int i);
        fs[i] = 1'b1;
        @(negedge clk);
        fs[i] = 1'b0;
        chk($sformatf("busy_on%0d", i), 64'(obs[i].busy), 1);
    endtask

    task automatic send(input int i, input logic [8:0] y, input logic last);
        int n;
        n = 0;
        sv[i] = 1'b1;
        sy[i] = y;
        sl[i] = last;
        while (!obs[i].sready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("sample_ready%0d", i), 64'(obs[i].sready), 1);
        @(negedge clk);
        sv[i] = 1'b0;
        sl[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        int n;
        n = 0;
        while (!obs[i].fd && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("frame_done%0d", i), 64'(obs[i].fd), 1);
        chk($sformatf("idle_busy%0d", i), 64'(obs[i].busy), 0);
        @(negedge clk);
        chk($sformatf("done_pulse%0d", i), 64'(obs[i].fd), 0);
    endtask

    task automatic chk_seg(input string name, input int i, input int x1,
                           input int y1, input int x2, input int y2);
        chk({name, "_start"}, 64'(obs[i].lstart), 1);
        chk({name, "_x1"}, 64'(obs[i].x1), 64'(x1));
        chk({name, "_y1"}, 64'(obs[i].y1), 64'(y1));
        chk({name, "_x2"}, 64'(obs[i].x2), 64'(x2));
        chk({name, "_y2"}, 64'(obs[i].y2), 64'(y2));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{0, 1'b1, 9'd100, 1'b1, 0, 379, 0, 379};
        vt[1]  = '{0, 1'b1, 9'd10,  1'b0, 0, 469, 0, 469};
        vt[2]  = '{0, 1'b0, 9'd12,  1'b0, 0, 469, 4, 467};
        vt[3]  = '{0, 1'b0, 9'd20,  1'b1, 4, 467, 8, 459};
        vt[4]  = '{0, 1'b1, 9'd0,   1'b0, 0, 479, 0, 479};
        vt[5]  = '{0, 1'b0, 9'd479, 1'b0, 0, 479, 4, 0};
        vt[6]  = '{0, 1'b0, 9'd511, 1'b1, 4, 0, 8, 0};
        vt[7]  = '{1, 1'b1, 9'd500, 1'b0, 0, 479, 0, 479};
        vt[8]  = '{1, 1'b0, 9'd3,   1'b0, 0, 479, 5, 3};
        vt[9]  = '{1, 1'b0, 9'd479, 1'b0, 5, 3, 10, 479};
        vt[10] = '{1, 1'b0, 9'd200, 1'b0, 10, 479, 15, 200};

        for (int i = 0; i < 2; i++) begin
            fs[i] = 1'b0;
            sv[i] = 1'b0;
            sl[i] = 1'b0;
            sy[i] = '0;
            stall[i] = 1'b0;
            starts[i] = 0;
        end

        #1 rst = 1'b1;
        #2;
        chk("reset_a", 64'(obs[0]), 0);
        chk("reset_b", 64'(obs[1]), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 11; k++) begin
            int i;
            i = vt[k].inst;
            if (vt[k].newf) start_frame(i);
            send(i, vt[k].y, vt[k].last);
            chk_seg($sformatf("v%0d", k), i, vt[k].x1, vt[k].y1,
                    vt[k].x2, vt[k].y2);
            if (vt[k].last) wait_done(i);
        end

        // Truncated frame: remaining samples are swallowed until last
        for (int j = 0; j < 6; j++) begin
            send(1, 9'(j * 7), j == 5);
            if (j < 5) chk("drain_busy", 64'(obs[1].busy), 1);
        end
        wait_done(1);
        chk("drain_starts", 64'(starts[1]), 4);
        chk("drain_x2", 64'(obs[1].x2), 15);

        // Drawer backpressure with a sample waiting upstream
        start_frame(0);
        stall[0] = 1'b1;
        send(0, 9'd50, 1'b0);
        sv[0] = 1'b1;
        sy[0] = 9'd60;
        sl[0] = 1'b1;
        for (int j = 0; j < 7; j++) begin
            chk_seg("bp", 0, 0, 429, 0, 429);
            chk("bp_sready", 64'(obs[0].sready), 0);
            @(negedge clk);
        end
        stall[0] = 1'b0;
        send(0, 9'd60, 1'b1);
        chk_seg("bp_next", 0, 0, 429, 4, 419);
        wait_done(0);

        // Asynchronous reset while the drawer is working
        start_frame(0);
        send(0, 9'd30, 1'b0);
        @(negedge clk);
        chk("pre_rst_busy", 64'(obs[0].busy), 1);
        chk("pre_rst_start", 64'(obs[0].lstart), 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_wait", 64'(obs[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_frame(0);
        send(0, 9'd100, 1'b1);
        chk_seg("post_rst", 0, 0, 379, 0, 379);
        wait_done(0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
